// File: rtl/seg7_pkg.sv
// seg7_pkg: constants shared by the 7-segment scanner and receiver.
//   - Segment patterns, ordered {a,b,c,d,e,f,g} and active-high.
//   - com_s digit-select one-hot codes. Digit 1 is the MSB.
//   - Receiver FSM state enum. Each state names the digit expected next.
//   - is_onehot4(): a helper that checks the digit select.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] COM_D1    = 4'b1000;
    localparam logic [3:0] COM_D2    = 4'b0100;
    localparam logic [3:0] COM_D3    = 4'b0010;
    localparam logic [3:0] COM_D4    = 4'b0001;
    localparam logic [3:0] COM_BLANK = 4'b0000;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_D2   = 2'd1,
        ST_D3   = 2'd2,
        ST_D4   = 2'd3
    } rx_state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational map from a segment pattern to a digit value.
//   seg_i   [6:0] : pattern {a,b,c,d,e,f,g}, active-high
//   val_o   [3:0] : decoded value. Returns 4'hF when the pattern is invalid.
//   valid_o       : 1 when the pattern is a recognised glyph
// Optional macro SEG7_HEX_DECODE_EN adds the A..F glyphs.
// Without the macro, those six patterns decode as invalid.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] val_o,
    output logic       valid_o
);

    always_comb begin
        val_o   = 4'hF;
        valid_o = 1'b1;
        case (seg_i)
            SEG_0: val_o = 4'h0;
            SEG_1: val_o = 4'h1;
            SEG_2: val_o = 4'h2;
            SEG_3: val_o = 4'h3;
            SEG_4: val_o = 4'h4;
            SEG_5: val_o = 4'h5;
            SEG_6: val_o = 4'h6;
            SEG_7: val_o = 4'h7;
            SEG_8: val_o = 4'h8;
            SEG_9: val_o = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
            SEG_A: val_o = 4'hA;
            SEG_B: val_o = 4'hB;
            SEG_C: val_o = 4'hC;
            SEG_D: val_o = 4'hD;
            SEG_E: val_o = 4'hE;
            SEG_F: val_o = 4'hF;
`endif
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx: receiver for a multiplexed 4-digit 7-segment bus.
// The block samples {com_s,seg_S,dp} and waits until a digit dwell has been
// stable for STABLE_CYCLES edges. It then captures that dwell once. It checks
// the digit order and rebuilds num1..num4 and the dp mask.
//   fin            : clock, rising edge
//   rst            : asynchronous reset, active-high
//   seg_S  [6:0]   : segments {a..g}
//   com_s  [3:0]   : digit select, one-hot. 1000 is digit 1. 0000 is blank.
//   dp             : decimal point of the selected digit
//   num1..num4 [3:0]: decoded digits. The value is F when the digit is undecodable.
//   dp_n   [3:0]   : dp mask. Bit 3 is digit 1.
//   frame_valid    : pulse when a clean, complete frame ends (digit 4 capture)
//   seg_err        : pulse when an undecodable pattern is captured
//   seq_err        : pulse when com_s is illegal or out of order
// Optional macro SEG7_HEX_DECODE_EN is handled inside seg7_decode.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       fin,
    input  logic       rst,
    input  logic [6:0] seg_S,
    input  logic [3:0] com_s,
    input  logic       dp,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic [3:0] dp_n,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       seq_err
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);

    logic [11:0]      s_q;
    logic [7:0]       stab_q, stab_d;
    logic             cap_q, cap_d;
    rx_state_e        st_q, st_d;
    logic             dirty_q, dirty_d;
    logic [3:0][3:0]  nums_q, nums_d;   // index 3 = digit 1, same as dp_n
    logic [3:0]       dpn_q, dpn_d;
    logic             fv_q, fv_d, seg_q, seg_d, seq_q, seq_d;

    logic [11:0] smp;
    logic        same, cap_ev, wr;
    logic [3:0]  exp_com;
    logic [3:0]  dec_val;
    logic        dec_ok;

    seg7_decode u_dec (
        .seg_i   (seg_S),
        .val_o   (dec_val),
        .valid_o (dec_ok)
    );

    assign smp  = {com_s, seg_S, dp};
    assign same = (smp == s_q);

    // The stability counter saturates. Any change on the bus re-arms
    // capture. The capture fires on the edge where the counter reaches
    // STAB_MAX, so the outputs land on the STABLE_CYCLES-th identical edge.
    always_comb begin
        stab_d = 8'd0;
        if (same)
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 8'd1;
    end

    assign cap_ev = (stab_d == STAB_MAX) && (com_s != COM_BLANK) && !cap_q;
    assign cap_d  = same & (cap_q | cap_ev);

    always_comb begin
        case (st_q)
            ST_D2:   exp_com = COM_D2;
            ST_D3:   exp_com = COM_D3;
            default: exp_com = COM_D4;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        dirty_d = dirty_q;
        nums_d  = nums_q;
        dpn_d   = dpn_q;
        wr      = 1'b0;
        fv_d    = 1'b0;
        seg_d   = 1'b0;
        seq_d   = 1'b0;

        if (cap_ev) begin
            if (!is_onehot4(com_s)) begin
                seq_d = 1'b1;
                st_d  = ST_SYNC;
            end else if (com_s == COM_D1) begin
                // Digit 1 starts or restarts a frame in every state.
                wr   = 1'b1;
                st_d = ST_D2;
            end else if (st_q != ST_SYNC) begin
                if (com_s == exp_com) begin
                    wr = 1'b1;
                    case (st_q)
                        ST_D2:   st_d = ST_D3;
                        ST_D3:   st_d = ST_D4;
                        default: st_d = ST_D2;   // digit 4 is followed by digit 1
                    endcase
                end else begin
                    seq_d = 1'b1;
                    st_d  = ST_SYNC;
                end
            end
            // In SYNC, digits 2..4 are dropped with no error.
        end

        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (com_s[i]) begin
                    nums_d[i] = dec_ok ? dec_val : 4'hF;
                    dpn_d[i]  = dp;
                end
            end
            seg_d   = !dec_ok;
            dirty_d = (com_s == COM_D1) ? !dec_ok : (dirty_q | !dec_ok);
            fv_d    = (st_q == ST_D4) && (com_s == COM_D4) && !dirty_q && dec_ok;
        end
    end

    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            stab_q  <= '0;
            cap_q   <= 1'b0;
            st_q    <= ST_SYNC;
            dirty_q <= 1'b0;
            nums_q  <= {4{4'hF}};
            dpn_q   <= '0;
            fv_q    <= 1'b0;
            seg_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            s_q     <= smp;
            stab_q  <= stab_d;
            cap_q   <= cap_d;
            st_q    <= st_d;
            dirty_q <= dirty_d;
            nums_q  <= nums_d;
            dpn_q   <= dpn_d;
            fv_q    <= fv_d;
            seg_q   <= seg_d;
            seq_q   <= seq_d;
        end
    end

    assign num1        = nums_q[3];
    assign num2        = nums_q[2];
    assign num3        = nums_q[1];
    assign num4        = nums_q[0];
    assign dp_n        = dpn_q;
    assign frame_valid = fv_q;
    assign seg_err     = seg_q;
    assign seq_err     = seq_q;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// tb_seg7_scan_rx: directed testbench for seg7_scan_rx with STABLE_CYCLES=4.
// Expected values follow the decode table and the frame rules, worked out by hand.
module tb_seg7_scan_rx;
    import seg7_pkg::*;

`ifdef SEG7_HEX_DECODE_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic       fin = 1'b0;
    logic       rst;
    logic [6:0] seg_S;
    logic [3:0] com_s;
    logic       dp;
    logic [3:0] num1, num2, num3, num4, dp_n;
    logic       frame_valid, seg_err, seq_err;

    seg7_scan_rx #(.STABLE_CYCLES(4)) dut (
        .fin         (fin),
        .rst         (rst),
        .seg_S       (seg_S),
        .com_s       (com_s),
        .dp          (dp),
        .num1        (num1),
        .num2        (num2),
        .num3        (num3),
        .num4        (num4),
        .dp_n        (dp_n),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .seq_err     (seq_err)
    );

    always #5 fin = ~fin;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         fv_cnt, seg_cnt, seq_cnt, fv_edge;
    logic [3:0] fv_num4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        fv_cnt  = 0;
        seg_cnt = 0;
        seq_cnt = 0;
        fv_edge = 0;
        fv_num4 = 4'h0;
    endtask

    // Holds one bus value for n rising edges. Samples run 1 time unit after each edge.
    task automatic dwell(input logic [3:0] c, input logic [6:0] s, input logic d, input int n);
        com_s   = c;
        seg_S   = s;
        dp      = d;
        fv_edge = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge fin);
            #1;
            if (frame_valid) begin
                fv_cnt++;
                fv_edge = i;
                fv_num4 = num4;
            end
            if (seg_err) seg_cnt++;
            if (seq_err) seq_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; com_s = '0; seg_S = '0; dp = 1'b0;
        clr();
        repeat (3) @(posedge fin);
        #1;
        chk("rst_nums",  {num1, num2, num3, num4}, 16'hFFFF);
        chk("rst_dpn",   dp_n, 4'h0);
        chk("rst_flags", {frame_valid, seg_err, seq_err}, 3'b000);
        rst = 1'b0;
        repeat (2) @(posedge fin);
        #1;

        // Clean frame 1,2,3,4 with dp 1,0,0,1
        clr();
        dwell(COM_D1, SEG_1, 1'b1, 16);
        chk("a_num1", num1, 4'h1);
        dwell(COM_D2, SEG_2, 1'b0, 16);
        dwell(COM_D3, SEG_3, 1'b0, 16);
        dwell(COM_D4, SEG_4, 1'b1, 16);
        chk("a_nums",    {num1, num2, num3, num4}, 16'h1234);
        chk("a_dpn",     dp_n, 4'b1001);
        chk("a_fv_cnt",  fv_cnt, 1);
        chk("a_fv_edge", fv_edge, 4);
        chk("a_fv_num4", fv_num4, 4'h4);
        chk("a_errs",    seg_cnt + seq_cnt, 0);

        // Repeated frame, new values
        clr();
        dwell(COM_D1, SEG_5, 1'b0, 16);
        dwell(COM_D2, SEG_6, 1'b1, 16);
        dwell(COM_D3, SEG_7, 1'b1, 16);
        dwell(COM_D4, SEG_8, 1'b0, 16);
        chk("b_nums",    {num1, num2, num3, num4}, 16'h5678);
        chk("b_dpn",     dp_n, 4'b0110);
        chk("b_fv_cnt",  fv_cnt, 1);
        chk("b_fv_edge", fv_edge, 4);

        // 2-cycle glitch to digit 2 inside a digit-1 dwell
        clr();
        dwell(COM_D1, SEG_9, 1'b0, 8);
        dwell(COM_D2, SEG_2, 1'b0, 2);
        dwell(COM_D1, SEG_9, 1'b0, 8);
        chk("g_nums", {num1, num2, num3, num4}, 16'h9678);
        chk("g_evts", fv_cnt + seg_cnt + seq_cnt, 0);

        // Bad pattern on digit 2 makes the frame dirty
        clr();
        dwell(COM_D1, SEG_1, 1'b0, 16);
        dwell(COM_D2, 7'b0000001, 1'b0, 16);
        dwell(COM_D3, SEG_3, 1'b0, 16);
        dwell(COM_D4, SEG_4, 1'b0, 16);
        chk("s_nums",    {num1, num2, num3, num4}, 16'h1F34);
        chk("s_seg_cnt", seg_cnt, 1);
        chk("s_fv_cnt",  fv_cnt, 0);
        chk("s_seq_cnt", seq_cnt, 0);

        // Next clean frame with minimum-length dwells
        clr();
        dwell(COM_D1, SEG_0, 1'b0, 4);
        dwell(COM_D2, SEG_2, 1'b0, 4);
        dwell(COM_D3, SEG_3, 1'b0, 4);
        dwell(COM_D4, SEG_9, 1'b0, 4);
        chk("c_nums",    {num1, num2, num3, num4}, 16'h0239);
        chk("c_fv_cnt",  fv_cnt, 1);
        chk("c_fv_edge", fv_edge, 4);
        chk("c_seg_cnt", seg_cnt, 0);

        // Out of order: 1 then 3
        clr();
        dwell(COM_D1, SEG_7, 1'b0, 16);
        dwell(COM_D3, SEG_5, 1'b0, 16);
        chk("q_seq_cnt", seq_cnt, 1);
        chk("q_seg_cnt", seg_cnt, 0);
        chk("q_nums",    {num1, num2, num3, num4}, 16'h7239);
        // In SYNC, digit 2 is dropped silently
        dwell(COM_D2, SEG_1, 1'b0, 16);
        chk("q_sync_nums", {num1, num2, num3, num4}, 16'h7239);
        chk("q_sync_seq",  seq_cnt, 1);
        clr();
        dwell(COM_D1, SEG_1, 1'b0, 16);
        dwell(COM_D2, SEG_2, 1'b0, 16);
        dwell(COM_D3, SEG_3, 1'b0, 16);
        dwell(COM_D4, SEG_4, 1'b0, 16);
        chk("q_fv_cnt", fv_cnt, 1);
        chk("q_nums2",  {num1, num2, num3, num4}, 16'h1234);

        // Non-one-hot select, then a long blank
        clr();
        dwell(4'b1100, SEG_8, 1'b0, 16);
        chk("i_seq_cnt", seq_cnt, 1);
        chk("i_seg_cnt", seg_cnt, 0);
        chk("i_nums",    {num1, num2, num3, num4}, 16'h1234);
        clr();
        dwell(COM_BLANK, SEG_8, 1'b1, 50);
        chk("blank_evts", fv_cnt + seg_cnt + seq_cnt, 0);
        chk("blank_nums", {num1, num2, num3, num4}, 16'h1234);

        // Hex glyph A on digit 1
        clr();
        dwell(COM_D1, SEG_A, 1'b0, 16);
        chk("h_num1",    num1, HEX ? 4'hA : 4'hF);
        chk("h_seg_cnt", seg_cnt, HEX ? 0 : 1);

        // A 3-edge dwell is one edge too short
        clr();
        dwell(COM_D2, SEG_7, 1'b0, 3);
        dwell(COM_BLANK, SEG_BLANK, 1'b0, 4);
        chk("short_num2", num2, 4'h2);
        chk("short_evts", fv_cnt + seg_cnt + seq_cnt, 0);

        // Asynchronous reset at the third digit
        clr();
        dwell(COM_D1, SEG_5, 1'b1, 16);
        dwell(COM_D2, SEG_6, 1'b0, 16);
        chk("r_pre_num2", num2, 4'h6);
        dwell(COM_D3, SEG_3, 1'b0, 2);
        #2;
        rst = 1'b1; com_s = '0; seg_S = '0; dp = 1'b0;
        #1;
        chk("r_nums",  {num1, num2, num3, num4}, 16'hFFFF);
        chk("r_dpn",   dp_n, 4'h0);
        chk("r_flags", {frame_valid, seg_err, seq_err}, 3'b000);
        @(posedge fin);
        #1;
        rst = 1'b0;
        clr();
        dwell(COM_D2, SEG_2, 1'b0, 16);
        chk("r_sync_num2", num2, 4'hF);
        chk("r_sync_seq",  seq_cnt, 0);
        clr();
        dwell(COM_D1, SEG_9, 1'b1, 16);
        dwell(COM_D2, SEG_8, 1'b1, 16);
        dwell(COM_D3, SEG_7, 1'b1, 16);
        dwell(COM_D4, SEG_6, 1'b1, 16);
        chk("r_nums2",  {num1, num2, num3, num4}, 16'h9876);
        chk("r_dpn2",   dp_n, 4'hF);
        chk("r_fv_cnt", fv_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_rx.md
# seg7_scan_rx

Receive side of the multiplexed 4-digit 7-segment bus: samples the scanned `seg_S`/`com_s`/`dp` lines, qualifies each digit dwell for stability, decodes segment patterns back to digit values and rebuilds the per-digit decimal-point mask. It sits on the panel side of the display scanner, or in the bench as a monitor. Its outputs are the same `num1..num4`/`dp_n` image the scanner was driven from, plus a per-frame valid strobe and error flags.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive `fin` edges over which `{com_s,seg_S,dp}` must be identical before capture; legal range 2..255.
- `fin  input  1`: sole clock; all logic on rising edge.
- `rst  input  1`: asynchronous, active-high reset.
- `seg_S  input  7`: segments `{a,b,c,d,e,f,g}`, active-high, synchronous to `fin`.
- `com_s  input  4`: digit select, one-hot; `1000`=digit 1 … `0001`=digit 4; `0000`=blank.
- `dp  input  1`: decimal point for the selected digit.
- `num1..num4  output  4 each`: decoded digit values.
- `dp_n  output  4`: dp mask, bit 3=digit 1 … bit 0=digit 4.
- `frame_valid  output  1`: one-cycle pulse on a complete clean frame.
- `seg_err  output  1`: one-cycle pulse on capture of an undecodable pattern.
- `seq_err  output  1`: one-cycle pulse on illegal or out-of-order `com_s`.

## Operation
- Reset values: `num1..num4`=4'hF, `dp_n`=0, `frame_valid`/`seg_err`/`seq_err`=0, FSM=`SYNC`, stability counter=0, captured flag=0.
- Input register `s_q` holds the `{com_s,seg_S,dp}` sample from the previous edge. Stability counter `stab` saturates at `STABLE_CYCLES-1`: it increments when the current sample equals `s_q` and clears otherwise. Any change clears the captured flag.
- A capture event fires once per dwell, when `stab` reaches `STABLE_CYCLES-1`, `com_s`≠0 and the captured flag is clear. It then sets the flag. `com_s`=0000 never captures and never changes state.
- At a capture with non-one-hot `com_s`: `seq_err` pulses, FSM goes to `SYNC`, no data is written.
- FSM states: `SYNC`, `D2`, `D3`, `D4`. The state names the digit expected next.
  - `SYNC`: only digit 1 is accepted; other one-hot digits are ignored silently. Digit 1 moves to `D2`.
  - `Dn`: digit n advances to the next state; `D4` returns to `D2`, because digit 4 is followed by digit 1. Digit 1 seen in `Dn` counts as a restart: it is written, a new frame starts, and no error is raised. Any other digit pulses `seq_err`, goes to `SYNC`, and is not written.
- Write: the decoded nibble goes to `numN` and `dp` goes to `dp_n[4-N]`. An undecodable pattern writes 4'hF, pulses `seg_err` and marks the frame dirty. The dirty flag clears when digit 1 is captured in an accepted sequence.
- A digit-4 capture in `D4` with the frame not dirty pulses `frame_valid`, in the same cycle the `num4` write becomes visible.
- Decode table (`abcdefg`): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.

## Timing
- The inputs change, then they are identical at edges 1..`STABLE_CYCLES`. Outputs and pulses update at edge `STABLE_CYCLES`; there is no further pipeline delay.
- A dwell shorter than `STABLE_CYCLES` edges is ignored entirely.
- Reset is asynchronous: asserting it mid-frame clears all state immediately, and the first capture after deassertion must be digit 1.
- `seg_err` and `seq_err` can never fire in the same cycle, because a `seq_err` capture is not decoded.

## Configuration
- `SEG7_HEX_DECODE_EN` defined: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111 decode to 4'hA–4'hF, and 4'hF is still returned for invalid patterns alongside `seg_err`.
- `SEG7_HEX_DECODE_EN` undefined: those six patterns are invalid and raise `seg_err`.

## Structure
- Shared package `seg7_pkg` holds the segment pattern constants, the `com_s` one-hot constants and the FSM state enum. The scanner and the receiver share these constants.
- One sub-module, `seg7_decode`: combinational mapping from 7-bit pattern to 4-bit value plus valid bit. The hex-decode macro is honoured inside it.

## Test plan
- Digits 1,2,3,4 with dp 1,0,0,1 and a 16-cycle dwell each → `num1..4`=1,2,3,4, `dp_n`=1001, one `frame_valid` pulse at the 4th edge of the digit-4 dwell; another pulse on each repeated frame.
- `com_s`=0100 for 2 cycles mid-dwell, then restore 1000 → no capture, no error, outputs unchanged.
- Digit 2 pattern 0000001 inside a frame → `num2`=F, `seg_err` pulse, no `frame_valid` for that frame; the next clean frame pulses `frame_valid`.
- Sequence 1000→0010 → `seq_err` pulse, `num3` unchanged, FSM in `SYNC`; then a full ordered frame → `frame_valid`.
- `com_s`=1100 stable → `seq_err`; `com_s`=0000 for 50 cycles → no events.
- With `SEG7_HEX_DECODE_EN`, digit 1=1110111 → `num1`=A, no `seg_err`. Without the macro → `num1`=F and `seg_err`. Separately, assert `rst` at the 3rd digit → all outputs at reset values immediately.
